// File: rtl/nr_iter_ctrl.sv
// Sequencing controller for a Broyden quasi-Newton solve loop (eval f, step, eval f, update, commit).
// Optional request watchdog is compiled in when NR_ITER_CTRL_WDOG_EN is defined.
module nr_iter_ctrl #(
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned WDOG_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       f_req,
  input  logic       f_ack,
  output logic       step_req,
  input  logic       step_ack,
  input  logic       conv,
  output logic       upd_req,
  input  logic       upd_ack,
  output logic       ld_state,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic       timeout,
  output logic [7:0] iter_cnt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL_F  = 3'd1,
    STEP    = 3'd2,
    EVAL_NF = 3'd3,
    UPDATE  = 3'd4,
    COMMIT  = 3'd5,
    FIN     = 3'd6
  } state_e;

  if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_chk_max_iter
    $error("nr_iter_ctrl: MAX_ITER must be in 1..255");
  end
  if (WDOG_CYC < 1) begin : g_chk_wdog_cyc
    $error("nr_iter_ctrl: WDOG_CYC must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic             converged_q, converged_d;
  logic             timeout_q, timeout_d;
  logic             f_req_q, f_req_d;
  logic             step_req_q, step_req_d;
  logic             upd_req_q, upd_req_d;
  logic             ld_state_q, ld_state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wdog_expired;

`ifdef NR_ITER_CTRL_WDOG_EN
  localparam int unsigned WDOG_W = 32;

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              req_state;
  logic              ack_here;

  // Expiry fires on the last allowed cycle of an unanswered request.
  always_comb begin
    req_state = 1'b0;
    ack_here  = 1'b0;
    unique case (state_q)
      EVAL_F, EVAL_NF: begin req_state = 1'b1; ack_here = f_ack;    end
      STEP:            begin req_state = 1'b1; ack_here = step_ack; end
      UPDATE:          begin req_state = 1'b1; ack_here = upd_ack;  end
      default:         begin req_state = 1'b0; ack_here = 1'b0;     end
    endcase
    wdog_expired = req_state && !ack_here && (wdog_cnt_q == WDOG_W'(WDOG_CYC - 1));
  end

  always_comb begin
    wdog_cnt_d = '0;
    if (req_state && (state_d == state_q)) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_cnt_q <= '0;
    else     wdog_cnt_q <= wdog_cnt_d;
  end
`else
  assign wdog_expired = 1'b0;
`endif

  // Next-state and result flags; abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    iter_cnt_d  = iter_cnt_q;
    converged_d = converged_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = EVAL_F;
          iter_cnt_d  = '0;
          converged_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      EVAL_F:  if (f_ack) state_d = STEP;
      STEP: begin
        if (step_ack) begin
          if (conv) begin
            state_d     = FIN;
            converged_d = 1'b1;
          end else begin
            state_d = EVAL_NF;
          end
        end
      end
      EVAL_NF: if (f_ack) state_d = UPDATE;
      UPDATE:  if (upd_ack) state_d = COMMIT;
      COMMIT: begin
        iter_cnt_d = iter_cnt_q + CNT_W'(1);
        state_d    = (iter_cnt_d == CNT_W'(MAX_ITER)) ? FIN : STEP;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wdog_expired) begin
      state_d     = FIN;
      timeout_d   = 1'b1;
      converged_d = 1'b0;
    end

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      iter_cnt_d  = iter_cnt_q;
      converged_d = converged_q;
      timeout_d   = timeout_q;
    end
  end

  // Moore outputs decoded from the next state so they are flopped alongside it.
  always_comb begin
    f_req_d    = (state_d == EVAL_F) || (state_d == EVAL_NF);
    step_req_d = (state_d == STEP);
    upd_req_d  = (state_d == UPDATE);
    ld_state_d = (state_d == COMMIT);
    done_d     = (state_d == FIN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      iter_cnt_q  <= '0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
      f_req_q     <= 1'b0;
      step_req_q  <= 1'b0;
      upd_req_q   <= 1'b0;
      ld_state_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_cnt_q  <= iter_cnt_d;
      converged_q <= converged_d;
      timeout_q   <= timeout_d;
      f_req_q     <= f_req_d;
      step_req_q  <= step_req_d;
      upd_req_q   <= upd_req_d;
      ld_state_q  <= ld_state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign f_req     = f_req_q;
  assign step_req  = step_req_q;
  assign upd_req   = upd_req_q;
  assign ld_state  = ld_state_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = converged_q;
  assign timeout   = timeout_q;
  assign iter_cnt  = iter_cnt_q;

endmodule
